// File: rtl/spram_bwe_pipe_if.sv
// Access bus of the single-port byte-write RAM: request and response
// signals grouped so clients connect through one port.
interface spram_bwe_pipe_if #(
    parameter int RAM_WIDTH = 32,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 256
);
    localparam int NB_COL = RAM_WIDTH / COL_WIDTH;
    localparam int AW     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic                 ena;
    logic [NB_COL-1:0]    wea;
    logic [AW-1:0]        addra;
    logic [RAM_WIDTH-1:0] dina;
    logic                 regcea;
    logic                 clr_req;
    logic [RAM_WIDTH-1:0] douta;
    logic                 douta_valid;
    logic                 init_busy;

    modport master (
        output ena, wea, addra, dina, regcea, clr_req,
        input  douta, douta_valid, init_busy
    );

    modport slave (
        input  ena, wea, addra, dina, regcea, clr_req,
        output douta, douta_valid, init_busy
    );
endinterface

// File: rtl/spram_bwe_pipe.sv
// Single-port RAM with column write enables, selectable write mode,
// 1..3 stage read pipeline with valid token and a hardware clear sweep.
module spram_bwe_pipe #(
    parameter int    RAM_WIDTH      = 32,
    parameter int    COL_WIDTH      = 8,
    parameter int    RAM_DEPTH      = 256,
    parameter string WRITE_MODE     = "WRITE_FIRST",
    parameter int    READ_LATENCY   = 2,
    parameter int    CLEAR_ON_RESET = 1
) (
    input  logic              clka,
    input  logic              rsta_n,
    spram_bwe_pipe_if.slave   bus
);
    localparam int NB_COL = RAM_WIDTH / COL_WIDTH;
    localparam int AW     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(RAM_DEPTH);
    localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
    localparam bit MODE_RF = (WRITE_MODE == "READ_FIRST");
    localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

    if (RAM_WIDTH % COL_WIDTH != 0) begin : g_bad_width
        $error("RAM_WIDTH must be a multiple of COL_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
        $error("READ_LATENCY must be 1..3");
    end
    if (!(MODE_WF || MODE_RF || MODE_NC)) begin : g_bad_mode
        $error("WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

    state_e               state_r;
    logic [AW-1:0]        clr_cnt_r;
    logic                 init_busy_r;
    logic [RAM_WIDTH-1:0] ram_r [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] d1_r;
    logic                 v1_r;

    logic                 acc_s;
    logic                 in_range_s;
    logic [RAM_WIDTH-1:0] old_s;
    logic [RAM_WIDTH-1:0] merged_s;
    logic [RAM_WIDTH-1:0] d1_nxt_s;
    logic                 v1_nxt_s;

    assign acc_s      = bus.ena & ~init_busy_r;
    assign in_range_s = ({1'b0, bus.addra} < DEPTH_EXT);

    // Current word at addra; out-of-range addresses read as zero
    always_comb begin
        old_s = '0;
        if (in_range_s) begin
            old_s = ram_r[bus.addra];
        end else begin
            old_s = '0;
        end
    end

    // Column merge of write data over the current word
    always_comb begin
        merged_s = old_s;
        for (int c = 0; c < NB_COL; c++) begin
            if (bus.wea[c]) begin
                merged_s[c*COL_WIDTH +: COL_WIDTH] = bus.dina[c*COL_WIDTH +: COL_WIDTH];
            end else begin
                merged_s[c*COL_WIDTH +: COL_WIDTH] = old_s[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // Stage-1 next value and valid token, by access type and write mode
    always_comb begin
        d1_nxt_s = d1_r;
        v1_nxt_s = 1'b0;
        if (!acc_s) begin
            d1_nxt_s = d1_r;
            v1_nxt_s = 1'b0;
        end else if (bus.wea == '0) begin
            d1_nxt_s = old_s;
            v1_nxt_s = 1'b1;
        end else if (MODE_WF) begin
            d1_nxt_s = merged_s;
            v1_nxt_s = 1'b1;
        end else if (MODE_RF) begin
            d1_nxt_s = old_s;
            v1_nxt_s = 1'b1;
        end else begin
            d1_nxt_s = d1_r;
            v1_nxt_s = 1'b0;
        end
    end

    // Clear sequencer; an abort by reset restarts the sweep from address 0
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_r     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            init_busy_r <= (CLEAR_ON_RESET != 0);
            clr_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clr_cnt_r <= '0;
                    if (bus.clr_req) begin
                        state_r     <= ST_CLEAR;
                        init_busy_r <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r     <= ST_IDLE;
                        init_busy_r <= 1'b0;
                        clr_cnt_r   <= '0;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    init_busy_r <= 1'b0;
                    clr_cnt_r   <= '0;
                end
            endcase
        end
    end

    // Array write port, shared between the clear sweep and client writes
    always_ff @(posedge clka) begin
        if (init_busy_r) begin
            ram_r[clr_cnt_r] <= '0;
        end else if (acc_s && in_range_s) begin
            for (int c = 0; c < NB_COL; c++) begin
                if (bus.wea[c]) begin
                    ram_r[bus.addra][c*COL_WIDTH +: COL_WIDTH] <= bus.dina[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // Stage 1: array output register
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            d1_r <= '0;
            v1_r <= 1'b0;
        end else begin
            d1_r <= d1_nxt_s;
            v1_r <= v1_nxt_s;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign bus.douta       = d1_r;
        assign bus.douta_valid = v1_r;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic [RAM_WIDTH-1:0] dq_r;
        logic                 vq_r;
        // Output stage, gated by regcea
        always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) begin
                dq_r <= '0;
                vq_r <= 1'b0;
            end else if (bus.regcea) begin
                dq_r <= d1_r;
                vq_r <= v1_r;
            end
        end
        assign bus.douta       = dq_r;
        assign bus.douta_valid = vq_r;
    end else begin : g_lat3
        logic [RAM_WIDTH-1:0] dm_r;
        logic                 vm_r;
        logic [RAM_WIDTH-1:0] dq_r;
        logic                 vq_r;
        // Free-running middle stage, then output stage gated by regcea
        always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) begin
                dm_r <= '0;
                vm_r <= 1'b0;
                dq_r <= '0;
                vq_r <= 1'b0;
            end else begin
                dm_r <= d1_r;
                vm_r <= v1_r;
                if (bus.regcea) begin
                    dq_r <= dm_r;
                    vq_r <= vm_r;
                end
            end
        end
        assign bus.douta       = dq_r;
        assign bus.douta_valid = vq_r;
    end

    assign bus.init_busy = init_busy_r;
endmodule

// File: doc/spram_bwe_pipe.md
Name: spram_bwe_pipe

Overview:
Next-generation single-port block RAM. It generalises the fixed no-change RAM with:
- selectable write mode (WRITE_FIRST / READ_FIRST / NO_CHANGE)
- per-column byte write enables
- a configurable read pipeline of 1–3 stages, with a douta_valid token
- a hardware clear sequencer that zeroes memory after reset or on request

It is the default single-port storage primitive for buffers and lookup tables in the datapath.

Parameters:
RAM_WIDTH, 32, data width in bits; must be a multiple of COL_WIDTH (elaboration $error otherwise).
COL_WIDTH, 8, bits per write-enable column; NB_COL = RAM_WIDTH/COL_WIDTH.
RAM_DEPTH, 256, number of words; need not be a power of 2.
WRITE_MODE, "WRITE_FIRST", one of "WRITE_FIRST", "READ_FIRST", "NO_CHANGE".
READ_LATENCY, 2, cycles from accepted read to douta; legal values 1..3.
CLEAR_ON_RESET, 1, when 1 the clear sweep runs automatically after reset release.

Ports:
clka  in  1  clock; all logic on rising edge.
rsta_n  in  1  asynchronous active-low reset.
ena  in  1  port enable; ignored while init_busy=1.
wea  in  NB_COL  per-column write enable.
addra  in  $clog2(RAM_DEPTH)  word address.
dina  in  RAM_WIDTH  write data.
regcea  in  1  final output stage load enable; ignored when READ_LATENCY=1.
clr_req  in  1  single-cycle request to zero the whole memory.
douta  out  RAM_WIDTH  read data.
douta_valid  out  1  douta carries the result of an accepted access.
init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rsta_n=0, async):
  - douta=0, douta_valid=0; all pipeline data and valid registers are 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Clear address counter is 0.
  - Memory array is not reset directly.
- FSM states and transitions:
  - IDLE -> CLEAR when clr_req=1.
  - CLEAR: writes 0 to address cnt each cycle, with cnt running 0..RAM_DEPTH-1.
  - CLEAR -> IDLE on the cycle that writes RAM_DEPTH-1. The sweep takes exactly RAM_DEPTH cycles.
  - clr_req during CLEAR is ignored; the sweep does not restart.
  - rsta_n asserted mid-sweep aborts the sweep. Afterwards it restarts from 0 per CLEAR_ON_RESET.
- init_busy = 1 iff state is CLEAR (registered). It is 1 immediately after reset when CLEAR_ON_RESET=1.
- Access acceptance: an access is accepted when ena=1 and init_busy=0.
- Accepted write (|wea=1):
  - Column c of ram[addra] takes dina[c*COL_WIDTH +: COL_WIDTH] where wea[c]=1; other columns are unchanged.
  - Stage-1 result depends on WRITE_MODE:
    - WRITE_FIRST: stage 1 loads the merged new word; valid token = 1.
    - READ_FIRST: stage 1 loads the old word; valid token = 1.
    - NO_CHANGE: stage 1 holds its value; valid token = 0.
- Accepted read (wea=0): stage 1 loads ram[addra]; valid token = 1.
- No accepted access: stage 1 data holds; valid token = 0.
- Out-of-range addresses (addra >= RAM_DEPTH): writes are dropped. Reads return 0 with valid=1.
- Pipeline:
  - Stage 1 is the array output register.
  - READ_LATENCY=2 adds an output register; READ_LATENCY=3 adds a middle register plus an output register.
  - The middle stage always advances.
  - The final stage (L>=2) loads data and valid only when regcea=1, otherwise it holds both.
  - Tokens overwritten upstream while regcea=0 are lost; the client must throttle.
- Latency: access accepted at edge N gives douta/douta_valid at edge N+READ_LATENCY-1, i.e. visible READ_LATENCY cycles after the request is presented (regcea=1 throughout).
- douta_valid is 0 for every cycle whose originating access was not accepted. This includes all CLEAR-period cycles.
- Simultaneous clr_req and an accepted access in IDLE: the access completes normally, and CLEAR starts on the next cycle.

Test Plan:
- Reset release with defaults: init_busy=1 for exactly 256 cycles. Then read addr 0..255 -> all douta=0x00000000, each valid 2 cycles after request.
- Write 0xDEADBEEF@0x10 (wea=4'hF), then wea=4'b0101 dina=0x11223344@0x10, then read 0x10 -> douta=0xDE22BE44.
- WRITE_MODE sweep, with ram[5]=0xAAAAAAAA and a write of 0x55555555@5:
  - WRITE_FIRST -> douta=0x55555555, valid=1.
  - READ_FIRST -> douta=0xAAAAAAAA, valid=1.
  - NO_CHANGE -> douta holds its previous value, valid=0.
- READ_LATENCY=1/2/3: a read issued at cycle T shows valid at T+1/T+2/T+3. For L=2, regcea=0 holds the prior douta and its valid.
- clr_req after filling memory with 0xFFFFFFFF: ena is ignored and valid=0 during the 256-cycle sweep. A second clr_req mid-sweep gives no extension. A post-sweep read returns 0.
- RAM_DEPTH=200 with a write at addr 250 -> ram unchanged. A read at 250 returns 0 with valid=1. rsta_n pulsed mid-sweep -> the sweep restarts from 0 and init_busy lasts 200 cycles.
